// File: rtl/pair_demux_collect.sv
// Collects five (in1, in2) pair beats into a 10-slot register bank and presents
// the bank as one parallel frame under a valid/ready handshake.

module pair_demux_collect_chk (
  input logic       clk,
  input logic       rst,
  input logic [2:0] sel
);
  // The pair index must never leave 0..4.
  sel_range: assert property (@(posedge clk) disable iff (rst) sel <= 3'd4);
endmodule

module pair_demux_collect #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  output logic [2:0]      sel,
  output logic [SIZE-1:0] out_0,
  output logic [SIZE-1:0] out_1,
  output logic [SIZE-1:0] out_2,
  output logic [SIZE-1:0] out_3,
  output logic [SIZE-1:0] out_4,
  output logic [SIZE-1:0] out_5,
  output logic [SIZE-1:0] out_6,
  output logic [SIZE-1:0] out_7,
  output logic [SIZE-1:0] out_8,
  output logic [SIZE-1:0] out_9,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t          state_r;
  state_t          next_state;
  logic [2:0]      next_sel;
  logic            wr_en;
  logic            accept;
  logic [SIZE-1:0] slot_r [10];

  assign accept = in_valid & in_ready;

  // Next-state, next pair index and bank write enable.
  always_comb begin
    next_state = state_r;
    next_sel   = sel;
    wr_en      = 1'b0;
    if (flush) begin
      // A beat presented alongside flush is dropped; the bank is left as is.
      next_state = FILL;
      next_sel   = 3'd0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept) begin
            wr_en = 1'b1;
            if (sel == 3'd4) begin
              next_sel   = 3'd0;
              next_state = HOLD;
            end else begin
              next_sel = sel + 3'd1;
            end
          end else begin
            next_sel = sel;
          end
        end
        HOLD: begin
          if (out_ready) begin
            next_state = FILL;
          end else begin
            next_state = HOLD;
          end
        end
        default: begin
          next_state = FILL;
          next_sel   = 3'd0;
        end
      endcase
    end
  end

  // State, pair index and handshake flags; the flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FILL;
      sel       <= 3'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= next_state;
      sel       <= next_sel;
      out_valid <= (next_state == HOLD);
      in_ready  <= (next_state == FILL);
    end
  end

  // Slot bank: an accepted beat lands in slots 2*sel and 2*sel+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        slot_r[i] <= '0;
      end
    end else if (wr_en) begin
      case (sel)
        3'd0: begin slot_r[0] <= in1; slot_r[1] <= in2; end
        3'd1: begin slot_r[2] <= in1; slot_r[3] <= in2; end
        3'd2: begin slot_r[4] <= in1; slot_r[5] <= in2; end
        3'd3: begin slot_r[6] <= in1; slot_r[7] <= in2; end
        3'd4: begin slot_r[8] <= in1; slot_r[9] <= in2; end
        default: begin end
      endcase
    end
  end

  assign out_0 = slot_r[0];
  assign out_1 = slot_r[1];
  assign out_2 = slot_r[2];
  assign out_3 = slot_r[3];
  assign out_4 = slot_r[4];
  assign out_5 = slot_r[5];
  assign out_6 = slot_r[6];
  assign out_7 = slot_r[7];
  assign out_8 = slot_r[8];
  assign out_9 = slot_r[9];

  pair_demux_collect_chk u_chk (
    .clk (clk),
    .rst (rst),
    .sel (sel)
  );

endmodule

// File: tb/tb_pair_demux_collect.sv
// Directed bench for pair_demux_collect: expected frames are queued as beats are
// driven and compared against the bank whenever out_valid is presented.

module tb_pair_demux_collect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in1 = 8'h00;
  logic [7:0] in2 = 8'h00;
  logic [2:0] sel;
  logic [7:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8, out_9;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [79:0] exp_q[$];
  logic [79:0] held;

  pair_demux_collect #(.SIZE(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2), .sel(sel),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
    .out_5(out_5), .out_6(out_6), .out_7(out_7), .out_8(out_8), .out_9(out_9),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] bank();
    return {out_9, out_8, out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};
  endfunction

  function automatic logic [79:0] seq_frame(input logic [7:0] base);
    logic [79:0] f;
    for (int k = 0; k < 10; k++) f[8*k +: 8] = base + 8'(k);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pair with in_valid=1 for one clock.
  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in1 = a; in2 = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then compare the bank with the oldest queued frame.
  task automatic check_frame(input string tag);
    logic [79:0] exp;
    for (int i = 0; i < 10 && out_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, 80'(out_valid), 80'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 80'd1, 80'd0);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_bank"}, bank(), exp);
    end
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_bank", bank(), 80'd0);
    chk("rst_sel", 80'(sel), 80'd0);
    chk("rst_valid", 80'(out_valid), 80'd0);
    chk("rst_ready", 80'(in_ready), 80'd1);

    // 2: five back-to-back beats
    exp_q.push_back(seq_frame(8'h10));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in1 = 8'h10 + 8'(2*k); in2 = 8'h11 + 8'(2*k);
      tick();
      chk($sformatf("b2b_sel%0d", k), 80'(sel), 80'((k + 1) % 5));
      chk($sformatf("b2b_valid%0d", k), 80'(out_valid), 80'(k == 4));
    end
    in_valid = 1'b0;
    check_frame("b2b");
    chk("b2b_hold_ready", 80'(in_ready), 80'd0);

    // 3: backpressure with 0xFF pairs offered
    held = bank();
    in_valid = 1'b1; in1 = 8'hFF; in2 = 8'hFF;
    for (int i = 0; i < 20; i++) tick();
    chk("bp_valid", 80'(out_valid), 80'd1);
    chk("bp_bank", bank(), held);
    chk("bp_sel", 80'(sel), 80'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_valid", 80'(out_valid), 80'd0);
    chk("bp_rel_ready", 80'(in_ready), 80'd1);

    // 4: gapped input
    exp_q.push_back(seq_frame(8'h30));
    for (int i = 0; i < 9; i++) begin
      in_valid = (i % 2 == 0);
      in1 = (i % 2 == 0) ? 8'h30 + 8'(i) : 8'hEE;
      in2 = (i % 2 == 0) ? 8'h31 + 8'(i) : 8'hEE;
      tick();
      chk($sformatf("gap_valid%0d", i), 80'(out_valid), 80'(i == 8));
      if (i < 8) chk($sformatf("gap_sel%0d", i), 80'(sel), 80'(i / 2 + 1));
    end
    in_valid = 1'b0;
    check_frame("gap");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 5: flush at sel=3 drops the presented pair and keeps the stale bank
    beat(8'h50, 8'h51); beat(8'h52, 8'h53); beat(8'h54, 8'h55);
    chk("fl_pre_sel", 80'(sel), 80'd3);
    flush = 1'b1; in_valid = 1'b1; in1 = 8'hAA; in2 = 8'hBB;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_sel", 80'(sel), 80'd0);
    chk("fl_valid", 80'(out_valid), 80'd0);
    chk("fl_slot67", 80'({out_7, out_6}), 80'h3736);
    chk("fl_slot0", 80'(out_0), 80'h50);
    exp_q.push_back(seq_frame(8'h20));
    for (int k = 0; k < 5; k++) beat(8'h20 + 8'(2*k), 8'h21 + 8'(2*k));
    check_frame("fl_next");
    // flush together with out_ready in HOLD discards the frame
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flrdy_valid", 80'(out_valid), 80'd0);
    chk("flrdy_ready", 80'(in_ready), 80'd1);
    chk("flrdy_bank", bank(), seq_frame(8'h20));

    // 6: reset while holding a frame
    exp_q.push_back(seq_frame(8'h60));
    for (int k = 0; k < 5; k++) beat(8'h60 + 8'(2*k), 8'h61 + 8'(2*k));
    check_frame("rh");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_valid", 80'(out_valid), 80'd0);
    chk("rh_bank", bank(), 80'd0);
    chk("rh_sel", 80'(sel), 80'd0);
    chk("rh_ready", 80'(in_ready), 80'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
